// File: rtl/mesh_seq_ctrl.sv
// mesh_seq_ctrl: per-job sequencer for the weight-stationary PE mesh
// (weight config stream, x-vector feed, accumulate sweep, store, done).
module mesh_seq_ctrl #(
    parameter int DW    = 8,
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int ROW_W = 2,
    parameter int COL_W = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   reuse_w,
    output logic                   busy,
    output logic                   done,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [DW-1:0]          w_data,
    input  logic                   x_valid,
    output logic                   x_ready,
    input  logic [COLS*DW-1:0]     x_data,
    output logic                   cfg_valid,
    output logic [ROW_W+COL_W-1:0] cfg_addr,
    output logic [DW-1:0]          cfg_data,
    output logic [1:0]             global_state,
    output logic [COLS*DW-1:0]     x_vector_flat
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CFG   = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] COMP  = 3'd3;
    localparam logic [2:0] STORE = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]       state, state_nx;
    logic [ROW_W-1:0] row_cnt, xcnt;
    logic [COL_W-1:0] col_cnt, ccnt;
    logic             wvalid;
    logic             w_hs, x_hs, col_end, w_last, x_last, c_last;

    assign w_hs    = state == CFG && w_valid;
    assign x_hs    = state == LOAD && x_valid;
    assign col_end = col_cnt == COL_W'(COLS - 1);
    assign w_last  = w_hs && col_end && row_cnt == ROW_W'(ROWS - 1);
    assign x_last  = x_hs && xcnt == ROW_W'(ROWS - 1);
    assign c_last  = state == COMP && ccnt == COL_W'(COLS - 1);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (reuse_w && wvalid) ? LOAD : CFG;
            CFG:     if (w_last) state_nx = LOAD;
            LOAD:    if (x_last) state_nx = COMP;
            COMP:    if (c_last) state_nx = STORE;
            STORE:   state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            row_cnt <= '0;
            col_cnt <= '0;
            xcnt    <= '0;
            ccnt    <= '0;
            wvalid  <= 1'b0;
        end else begin
            state <= state_nx;
            if (w_hs) begin
                col_cnt <= col_end ? '0 : col_cnt + COL_W'(1);
                row_cnt <= w_last ? '0 : row_cnt + ROW_W'(col_end);
            end
            if (w_last) wvalid <= 1'b1;
            if (x_hs) xcnt <= x_last ? '0 : xcnt + ROW_W'(1);
            if (state == COMP) ccnt <= c_last ? '0 : ccnt + COL_W'(1);
        end
    end

    // Config and x outputs are gated by the handshake so the mesh never sees stale data on stalls.
    assign busy          = state != IDLE;
    assign done          = state == DONE;
    assign w_ready       = state == CFG;
    assign x_ready       = state == LOAD;
    assign cfg_valid     = w_hs;
    assign cfg_addr      = w_hs ? {row_cnt, col_cnt} : '0;
    assign cfg_data      = w_hs ? w_data : '0;
    assign x_vector_flat = x_hs ? x_data : '0;
    assign global_state  = x_hs ? 2'd1 : state == COMP ? 2'd2 : state == STORE ? 2'd3 : 2'd0;
endmodule

// File: tb/tb_mesh_seq_ctrl.sv
// tb_mesh_seq_ctrl: directed and randomized jobs checked against a
// remaining-work-count reference model of the sequencer.
module tb_mesh_seq_ctrl;
    localparam int DW = 8, ROWS = 4, COLS = 4, ROW_W = 2, COL_W = 2;
    localparam int NW = ROWS * COLS, XW = COLS * DW;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, reuse_w = 1'b0;
    logic w_valid = 1'b0, x_valid = 1'b0;
    logic [DW-1:0] w_data = '0;
    logic [XW-1:0] x_data = '0;
    logic busy, done, w_ready, x_ready, cfg_valid;
    logic [ROW_W+COL_W-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;
    logic [1:0] global_state;
    logic [XW-1:0] x_vector_flat;

    mesh_seq_ctrl #(.DW(DW), .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .reuse_w(reuse_w), .busy(busy), .done(done),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .global_state(global_state), .x_vector_flat(x_vector_flat)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    // model: remaining weights, x-vectors, accumulate cycles, tail (store + done)
    bit m_act = 0, m_wv = 0;
    int m_nw = 0, m_nx = 0, m_nc = 0, m_tail = 0;
    logic s_done, s_cfg;
    logic [1:0] s_gs;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic e_wr, e_xr, e_cv, e_done, e_comp, e_store;
        logic [1:0] e_gs;
        int idx;
        e_wr    = m_act && m_nw > 0;
        e_xr    = m_act && m_nw == 0 && m_nx > 0;
        e_comp  = m_act && m_nw == 0 && m_nx == 0 && m_nc > 0;
        e_store = m_act && m_nw == 0 && m_nx == 0 && m_nc == 0 && m_tail == 2;
        e_done  = m_act && m_nw == 0 && m_nx == 0 && m_nc == 0 && m_tail == 1;
        e_cv    = e_wr && w_valid;
        e_gs    = (e_xr && x_valid) ? 2'd1 : e_comp ? 2'd2 : e_store ? 2'd3 : 2'd0;
        idx     = NW - m_nw;
        check("busy", 64'(busy), 64'(m_act));
        check("done", 64'(done), 64'(e_done));
        check("w_ready", 64'(w_ready), 64'(e_wr));
        check("x_ready", 64'(x_ready), 64'(e_xr));
        check("cfg_valid", 64'(cfg_valid), 64'(e_cv));
        check("cfg_addr", 64'(cfg_addr), e_cv ? 64'(((idx / COLS) << COL_W) | (idx % COLS)) : 64'd0);
        check("cfg_data", 64'(cfg_data), e_cv ? 64'(w_data) : 64'd0);
        check("global_state", 64'(global_state), 64'(e_gs));
        check("x_vector_flat", 64'(x_vector_flat), (e_xr && x_valid) ? 64'(x_data) : 64'd0);
    endtask

    task automatic model_update();
        if (!m_act) begin
            if (start) begin
                m_act = 1; m_nw = (reuse_w && m_wv) ? 0 : NW;
                m_nx = ROWS; m_nc = COLS; m_tail = 2;
            end
        end else if (m_nw > 0) begin
            if (w_valid) begin
                m_nw--;
                if (m_nw == 0) m_wv = 1;
            end
        end else if (m_nx > 0) begin
            if (x_valid) m_nx--;
        end else if (m_nc > 0) m_nc--;
        else begin
            m_tail--;
            if (m_tail == 0) m_act = 0;
        end
    endtask

    task automatic step();
        #1 check_outputs();
        s_done = done; s_cfg = cfg_valid; s_gs = global_state;
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        m_act = 0; m_wv = 0;
        #1 check_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_job(input bit reuse, input int wmode, input int xmode, input int exp_lat, input int exp_writes);
        int writes, g1, g2, g3;
        bit got;
        start = 1'b1; reuse_w = reuse; w_valid = 1'b0; x_valid = 1'b0;
        step();
        writes = 0; g1 = 0; g2 = 0; g3 = 0; got = 0;
        for (int n = 1; n <= 300 && !got; n++) begin
            start   = 1'($urandom_range(0, 1));
            reuse_w = 1'($urandom_range(0, 1));
            w_valid = wmode == 0 ? 1'b1 : 1'(n % 4 == 1);
            w_data  = m_nw > 0 ? DW'(NW + 1 - m_nw) : DW'($urandom);
            x_valid = xmode == 0 ? 1'b1 : 1'(n % 2);
            x_data  = XW'($urandom);
            step();
            writes += int'(s_cfg);
            g1 += int'(s_gs == 2'd1); g2 += int'(s_gs == 2'd2); g3 += int'(s_gs == 2'd3);
            if (s_done) begin
                got = 1;
                if (exp_lat >= 0) check("latency", 64'(n), 64'(exp_lat));
            end
        end
        start = 1'b0;
        check("done_seen", 64'(got), 64'd1);
        check("cfg_writes", 64'(writes), 64'(exp_writes));
        check("gs1_count", 64'(g1), 64'(ROWS));
        check("gs2_count", 64'(g2), 64'(COLS));
        check("gs3_count", 64'(g3), 64'd1);
    endtask

    initial begin
        #2 check_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        run_job(0, 0, 0, NW + ROWS + COLS + 2, NW);
        run_job(1, 0, 0, ROWS + COLS + 2, 0);
        run_job(0, 1, 0, -1, NW);
        run_job(1, 0, 1, -1, 0);
        start = 1'b1; reuse_w = 1'b0;
        step();
        start = 1'b0;
        for (int n = 0; n < 100 && !(m_act && m_nw == 0 && m_nx == 0 && m_nc == 2); n++) begin
            w_valid = 1'b1; x_valid = 1'b1;
            w_data = m_nw > 0 ? DW'(NW + 1 - m_nw) : '0;
            x_data = XW'($urandom);
            step();
        end
        check("reached_comp", 64'(global_state), 64'd2);
        do_reset();
        check("busy_after_reset", 64'(busy), 64'd0);
        run_job(1, 0, 0, NW + ROWS + COLS + 2, NW);
        for (int n = 0; n < 3000; n++) begin
            start   = 1'($urandom_range(0, 7) == 0);
            reuse_w = 1'($urandom_range(0, 1));
            w_valid = 1'($urandom_range(0, 3) != 0);
            x_valid = 1'($urandom_range(0, 2) != 0);
            w_data  = DW'($urandom);
            x_data  = XW'($urandom);
            if ($urandom_range(0, 399) == 0) do_reset();
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mesh_seq_ctrl.md
Name: mesh_seq_ctrl

Overview:
- Sequencer for the 2-D weight-stationary PE mesh; owns the mesh's `global_state`, `cfg_*` and `x_vector_flat` inputs.
- Per job:
  - streams ROWS*COLS weights into the tiles through the config bus (skipped on weight reuse);
  - feeds ROWS x-vectors down the columns;
  - runs the accumulate sweep across the columns;
  - issues the STORE cycle and signals `done` when `result_flat` is valid.

Parameters:
- DW, 8, data width of weights and x elements.
- ROWS, 4, mesh rows.
- COLS, 4, mesh columns.
- ROW_W, 2, row index width (2^ROW_W >= ROWS).
- COL_W, 2, column index width (2^COL_W >= COLS).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job request; sampled only in IDLE.
- reuse_w  in  1  sampled with start; 1 = skip weight load if weights are valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; `result_flat` of the mesh is valid this cycle.
- w_valid  in  1  weight stream valid.
- w_ready  out  1  weight stream ready.
- w_data  in  DW  weight, row-major order (r0c0, r0c1, ...).
- x_valid  in  1  x-vector stream valid.
- x_ready  out  1  x-vector stream ready.
- x_data  in  COLS*DW  x-vector; element c in bits [(c+1)*DW-1 -: DW].
- cfg_valid  out  1  mesh config write strobe.
- cfg_addr  out  ROW_W+COL_W  {row, col} of the target tile.
- cfg_data  out  DW  weight to write.
- global_state  out  2  mesh phase: 0 = hold, 1 = x shift, 2 = accumulate, 3 = store.
- x_vector_flat  out  COLS*DW  x-vector into mesh row 0.

Behaviour:
- Reset (async, rst_n=0): FSM goes to IDLE; counters and the wvalid flag clear. All outputs are 0 during and after reset.
- Reset mid-job: the job is abandoned and wvalid clears; a new `start` is required.
- FSM states: IDLE, CFG, LOAD, COMP, STORE, DONE.
- IDLE, `global_state` = 0.
  - start=1 with reuse_w=1 and wvalid=1 → LOAD.
  - start=1 otherwise → CFG. This includes reuse_w=1 while wvalid=0.
  - start is ignored in all other states.
- CFG, `global_state` = 0, `w_ready` = 1.
  - Handshake = w_valid & w_ready.
  - On a handshake, combinationally in the same cycle: `cfg_valid` = 1, `cfg_addr` = {row_cnt, col_cnt}, `cfg_data` = w_data.
  - col_cnt increments and wraps at COLS-1 to 0, then row_cnt increments.
  - Cycles with w_valid=0 are stalls: no write, counters hold.
  - On handshake ROWS*COLS: counters clear, wvalid is set, next state is LOAD.
- LOAD, `x_ready` = 1.
  - Handshake cycle: `global_state` = 1, `x_vector_flat` = x_data, xcnt increments.
  - Stall cycle (x_valid=0): `global_state` = 0 and `x_vector_flat` = 0. The mesh must not shift on stall cycles.
  - On handshake ROWS: xcnt clears, next state is COMP.
- COMP: `global_state` = 2 for exactly COLS consecutive cycles, counted by ccnt, then STORE.
- STORE: `global_state` = 3 for one cycle. The mesh registers its results at the end of this cycle.
- DONE: `done` = 1 and `global_state` = 0 for one cycle, then IDLE.
- Outside their active states: `w_ready`, `x_ready` and `cfg_valid` are 0; `cfg_addr`, `cfg_data` and `x_vector_flat` are 0.
- Latency with no stalls, measured from the start-sampling edge to the done cycle inclusive:
  - with CFG: ROWS*COLS + ROWS + COLS + 2 cycles;
  - with reuse: ROWS + COLS + 2 cycles.
- wvalid persists across jobs and is cleared only by reset.
- Extra w_valid or x_valid outside CFG/LOAD is not accepted (ready is 0).

Test Plan:
- Defaults, start=1 reuse_w=0, weights 1..16 presented back-to-back:
  - 16 cfg writes with addr 0x0..0xF and data 1..16;
  - then gs=1 ×4, gs=2 ×4, gs=3 ×1;
  - done pulses exactly 26 cycles after the start edge.
- Second job with reuse_w=1: no cfg_valid, no w_ready; done 10 cycles after start.
- reuse_w=1 as the first job after reset: CFG still runs and all 16 writes are issued.
- x_valid low on alternate cycles during LOAD:
  - gs=1 only on the 4 handshake cycles, gs=0 and x_vector_flat=0 on stall cycles;
  - COMP starts after the 4th handshake.
- w_valid stalls of 3 cycles during CFG: cfg_addr sequence unbroken, no duplicate writes, 16 writes total.
- Reset asserted during COMP:
  - all outputs 0 immediately; FSM in IDLE;
  - a subsequent reuse_w=1 start goes to CFG;
  - start pulsed while busy has no effect.
